// File: rtl/segment_capture.sv
// segment_capture
//   Recovers the hex value shown on a multiplexed 4-digit 7-segment display
//   by watching its segment and digit-select lines. Each {dig_sel,seg} sample
//   is synchronized and debounced. A run of STABLE_CYC repeats after the first
//   sample yields one accept. Accepted digits are collected in order
//   digit0..digit3 and presented as a frame with a valid/ready handshake.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   seg[7:0]     {dp,g,f,e,d,c,b,a}, 1 = lit (asynchronous)
//   dig_sel[3:0] one-hot digit enable, bit0 = rightmost (asynchronous)
//   frame_ready  consumer takes the frame when high with frame_valid
//   value[15:0]  captured frame, digit3 in [15:12] .. digit0 in [3:0]
//   dp_out[3:0]  captured decimal points, bit i = digit i
//   frame_valid  value/dp_out hold an unconsumed frame
//   err          one-cycle pulse on an undecodable accepted pattern
//   ovf          sticky, a completed frame was dropped
module segment_capture #(
    parameter int unsigned STABLE_CYC = 4  // legal range 2..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg,
    input  logic [3:0]  dig_sel,
    input  logic        frame_ready,
    output logic [15:0] value,
    output logic [3:0]  dp_out,
    output logic        frame_valid,
    output logic        err,
    output logic        ovf
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYC);
    localparam logic [3:0] CNT_PRE = 4'(STABLE_CYC - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // {valid, nibble} for the a..g segment pattern
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3F: r = {1'b1, 4'h0};
            7'h06: r = {1'b1, 4'h1};
            7'h5B: r = {1'b1, 4'h2};
            7'h4F: r = {1'b1, 4'h3};
            7'h66: r = {1'b1, 4'h4};
            7'h6D: r = {1'b1, 4'h5};
            7'h7D: r = {1'b1, 4'h6};
            7'h07: r = {1'b1, 4'h7};
            7'h7F: r = {1'b1, 4'h8};
            7'h6F: r = {1'b1, 4'h9};
            7'h77: r = {1'b1, 4'hA};
            7'h7C: r = {1'b1, 4'hB};
            7'h39: r = {1'b1, 4'hC};
            7'h5E: r = {1'b1, 4'hD};
            7'h79: r = {1'b1, 4'hE};
            7'h71: r = {1'b1, 4'hF};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    logic [11:0] sync1_q, sync1_d;
    logic [11:0] sync2_q, sync2_d;
    logic [11:0] prev_q, prev_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        acc_q, acc_d;
    logic [11:0] acc_smp_q, acc_smp_d;
    state_t      state_q, state_d;
    logic [1:0]  exp_q, exp_d;
    logic [15:0] buf_q, buf_d;
    logic [3:0]  dpb_q, dpb_d;
    logic [15:0] value_q, value_d;
    logic [3:0]  dp_q, dp_d;
    logic        fv_q, fv_d;
    logic        err_q, err_d;
    logic        ovf_q, ovf_d;

    logic        same;
    logic [3:0]  acc_sel;
    logic [7:0]  acc_seg;
    logic [4:0]  dec;
    logic [1:0]  idx;
    logic        complete;
    logic        load;

    // Synchronizer, debounce counter and accept detection
    always_comb begin
        sync1_d   = {dig_sel, seg};
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        same      = (sync2_q == prev_q);
        cnt_d     = 4'd0;
        if (same) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
        end
        // Fires only on the transition into saturation, so a held input
        // produces exactly one accept.
        acc_d     = same && (cnt_q == CNT_PRE);
        acc_smp_d = sync2_q;
    end

    // Digit collection FSM and frame output
    always_comb begin
        acc_sel  = acc_smp_q[11:8];
        acc_seg  = acc_smp_q[7:0];
        dec      = seg_decode(acc_seg[6:0]);
        idx      = 2'd0;
        case (acc_sel)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase

        state_d  = state_q;
        exp_d    = exp_q;
        buf_d    = buf_q;
        dpb_d    = dpb_q;
        err_d    = 1'b0;
        complete = 1'b0;

        // Zero or multi-hot selects are ignored entirely.
        if (acc_q && $onehot(acc_sel)) begin
            if (!dec[4]) begin
                err_d   = 1'b1;
                state_d = IDLE;
                exp_d   = 2'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (idx == 2'd0) begin
                            buf_d[3:0] = dec[3:0];
                            dpb_d[0]   = acc_seg[7];
                            exp_d      = 2'd1;
                            state_d    = COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (idx == exp_q) begin
                            buf_d[{idx, 2'b00} +: 4] = dec[3:0];
                            dpb_d[idx]               = acc_seg[7];
                            if (exp_q == 2'd3) begin
                                complete = 1'b1;
                                state_d  = IDLE;
                                exp_d    = 2'd0;
                            end else begin
                                exp_d = exp_q + 2'd1;
                            end
                        end else if (idx == 2'd0) begin
                            // Display wrapped back to digit0: restart frame.
                            buf_d[3:0] = dec[3:0];
                            dpb_d[0]   = acc_seg[7];
                            exp_d      = 2'd1;
                        end else begin
                            state_d = IDLE;
                            exp_d   = 2'd0;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        exp_d   = 2'd0;
                    end
                endcase
            end
        end

        // A held frame is never overwritten unless it is consumed this cycle.
        load    = complete && (!fv_q || frame_ready);
        value_d = load ? buf_d : value_q;
        dp_d    = load ? dpb_d : dp_q;
        fv_d    = fv_q;
        if (load) begin
            fv_d = 1'b1;
        end else if (fv_q && frame_ready) begin
            fv_d = 1'b0;
        end
        ovf_d   = ovf_q | (complete && fv_q && !frame_ready);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            acc_q     <= 1'b0;
            acc_smp_q <= '0;
            state_q   <= IDLE;
            exp_q     <= 2'd0;
            buf_q     <= '0;
            dpb_q     <= '0;
            value_q   <= '0;
            dp_q      <= '0;
            fv_q      <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            acc_smp_q <= acc_smp_d;
            state_q   <= state_d;
            exp_q     <= exp_d;
            buf_q     <= buf_d;
            dpb_q     <= dpb_d;
            value_q   <= value_d;
            dp_q      <= dp_d;
            fv_q      <= fv_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

    assign value       = value_q;
    assign dp_out      = dp_q;
    assign frame_valid = fv_q;
    assign err         = err_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_segment_capture.sv
module tb_segment_capture;

    localparam int STABLE_CYC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg;
    logic [3:0]  dig_sel;
    logic        frame_ready;
    logic [15:0] value;
    logic [3:0]  dp_out;
    logic        frame_valid;
    logic        err;
    logic        ovf;

    segment_capture #(.STABLE_CYC(STABLE_CYC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .dig_sel     (dig_sel),
        .frame_ready (frame_ready),
        .value       (value),
        .dp_out      (dp_out),
        .frame_valid (frame_valid),
        .err         (err),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Observers: delivered frames {dp_out,value}, err pulses, valid cycles.
    logic [19:0] frm_q[$];
    int err_cnt = 0;
    int fv_cycles = 0;
    always @(negedge clk) begin
        if (err) err_cnt <= err_cnt + 1;
        if (frame_valid) fv_cycles <= fv_cycles + 1;
        if (frame_valid && frame_ready) frm_q.push_back({dp_out, value});
    end

    function automatic logic [6:0] pat_of(input int n);
        case (n)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [3:0] s, input logic [7:0] g, input int n);
        dig_sel = s;
        seg     = g;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [15:0] v, input logic [3:0] dps, input int n);
        for (int i = 0; i < 4; i++)
            hold(4'(1 << i), {dps[i], pat_of(int'(v[4*i +: 4]))}, n);
    endtask

    task automatic scan_raw(input logic [6:0] p, input logic [3:0] dps, input int n);
        for (int i = 0; i < 4; i++)
            hold(4'(1 << i), {dps[i], p}, n);
    endtask

    task automatic flush();
        hold(4'h0, 8'h00, 16);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hold(4'h0, 8'h00, 2);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [6:0]  pat;
        logic [3:0]  dps;
        logic [15:0] exp_val;
        int          exp_frames;
        int          exp_errs;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int nf, ne, nc, first;
        rst_n = 1'b0; seg = 8'h00; dig_sel = 4'h0; frame_ready = 1'b1;

        for (int i = 0; i < 16; i++)
            tbl[i] = '{pat_of(i), 4'(i), {4{4'(i)}}, 1, 0};
        tbl[16] = '{7'h00, 4'h0, 16'h0, 0, 4};
        tbl[17] = '{7'h7E, 4'h5, 16'h0, 0, 4};
        tbl[18] = '{7'h01, 4'h0, 16'h0, 0, 4};
        tbl[19] = '{7'h40, 4'hF, 16'h0, 0, 4};

        @(posedge clk); #1;
        hold(4'h0, 8'h00, 3);
        chk("rst_value", 32'(value), 0);
        chk("rst_dp", 32'(dp_out), 0);
        chk("rst_fv", 32'(frame_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst_n = 1'b1;
        flush();

        // Basic scan 0..3
        nf = frm_q.size(); ne = err_cnt; nc = fv_cycles;
        hold(4'b0001, 8'h3F, 8); hold(4'b0010, 8'h06, 8);
        hold(4'b0100, 8'h5B, 8); hold(4'b1000, 8'h4F, 8);
        flush();
        chk("scan_frames", frm_q.size() - nf, 1);
        chk("scan_value", 32'(value), 32'h3210);
        chk("scan_dp", 32'(dp_out), 0);
        chk("scan_fv_cycles", fv_cycles - nc, 1);
        chk("scan_err", err_cnt - ne, 0);

        // Decode table
        foreach (tbl[k]) begin
            nf = frm_q.size(); ne = err_cnt;
            scan_raw(tbl[k].pat, tbl[k].dps, 6);
            flush();
            chk($sformatf("tbl%0d_frames", k), frm_q.size() - nf, tbl[k].exp_frames);
            chk($sformatf("tbl%0d_errs", k), err_cnt - ne, tbl[k].exp_errs);
            if (tbl[k].exp_frames == 1 && frm_q.size() > nf)
                chk($sformatf("tbl%0d_frame", k), 32'(frm_q[nf]), {12'h0, tbl[k].dps, tbl[k].exp_val});
        end

        // Latency from the last digit's first sampled edge
        hold(4'b0001, 8'h3F, 8); hold(4'b0010, 8'h06, 8); hold(4'b0100, 8'h5B, 8);
        dig_sel = 4'b1000; seg = 8'h4F; first = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (frame_valid && first == 0) first = n;
        end
        chk("latency_edges", first, STABLE_CYC + 4);
        flush();

        // Bad digit2 pattern, then an all-F scan
        nf = frm_q.size(); ne = err_cnt;
        hold(4'b0001, 8'h71, 8); hold(4'b0010, 8'h71, 8);
        hold(4'b0100, 8'h7E, 8); hold(4'b1000, 8'h71, 8);
        flush();
        chk("bad_err", err_cnt - ne, 1);
        chk("bad_frames", frm_q.size() - nf, 0);
        scan_raw(7'h71, 4'h0, 8);
        flush();
        chk("ffff_value", 32'(value), 32'hFFFF);

        // Holds too short to accept
        nf = frm_q.size(); ne = err_cnt;
        scan(16'h3210, 4'h0, 3);
        flush();
        chk("short_frames", frm_q.size() - nf, 0);
        chk("short_fv", 32'(frame_valid), 0);

        // Out-of-order abort, then complete frame
        nf = frm_q.size();
        hold(4'b0001, 8'h6D, 8); hold(4'b0010, 8'h6D, 8); hold(4'b1000, 8'h6D, 8);
        scan_raw(7'h6D, 4'h0, 8);
        flush();
        chk("abort_frames", frm_q.size() - nf, 1);
        chk("abort_value", 32'(value), 32'h5555);
        // Multi-hot accept in the middle of a frame leaves the FSM untouched
        nf = frm_q.size(); ne = err_cnt;
        hold(4'b0001, 8'h6D, 8); hold(4'b0011, 8'h3F, 8);
        hold(4'b0010, 8'h6D, 8); hold(4'b0100, 8'h6D, 8); hold(4'b1000, 8'h6D, 8);
        flush();
        chk("multihot_frames", frm_q.size() - nf, 1);
        chk("multihot_err", err_cnt - ne, 0);
        chk("ovf_before", 32'(ovf), 0);

        // Backpressure: second frame dropped
        frame_ready = 1'b0;
        scan(16'h8421, 4'h0, 8);
        scan(16'h1234, 4'h1, 8);
        flush();
        chk("bp_fv", 32'(frame_valid), 1);
        chk("bp_value", 32'(value), 32'h8421);
        chk("bp_dp", 32'(dp_out), 0);
        chk("bp_ovf", 32'(ovf), 1);
        frame_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_fv_clear", 32'(frame_valid), 0);
        chk("bp_ovf_sticky", 32'(ovf), 1);

        // Reset mid-frame
        hold(4'b0001, 8'h06, 8); hold(4'b0010, 8'h06, 8); hold(4'b0100, 8'h06, 8);
        rst_n = 1'b0;
        hold(4'h0, 8'h00, 1);
        chk("mid_rst_value", 32'(value), 0);
        chk("mid_rst_dp", 32'(dp_out), 0);
        chk("mid_rst_ovf", 32'(ovf), 0);
        chk("mid_rst_fv", 32'(frame_valid), 0);
        rst_n = 1'b1;
        nf = frm_q.size();
        hold(4'b0010, 8'h06, 8); hold(4'b0100, 8'h06, 8); hold(4'b1000, 8'h06, 8);
        flush();
        chk("mid_rst_frames", frm_q.size() - nf, 0);
        chk("mid_rst_value2", 32'(value), 0);

        // Randomized run against an abstract model
        do_reset();
        flush();
        begin
            logic [11:0] prev_s;
            logic [3:0]  md[4];
            logic [3:0]  mdp;
            logic [19:0] exp_fr[$];
            int run, have, exp_err, cur;
            bit fired;
            prev_s = 12'h000; run = 1000; fired = 1; have = 0; exp_err = 0; cur = 0;
            mdp = 4'h0;
            for (int i = 0; i < 4; i++) md[i] = 4'h0;
            nf = frm_q.size(); ne = err_cnt;
            for (int t = 0; t < 160; t++) begin
                logic [3:0] s;
                logic [7:0] g;
                int h, d, pos;
                if ($urandom_range(0, 9) < 7) begin
                    s = 4'(1 << cur);
                    cur = (cur + 1) % 4;
                end else begin
                    s = 4'($urandom_range(0, 15));
                end
                if ($urandom_range(0, 9) < 9)
                    g = {1'($urandom_range(0, 1)), pat_of($urandom_range(0, 15))};
                else
                    g = 8'($urandom_range(0, 255));
                h = $urandom_range(2, 8);

                if ({s, g} == prev_s) run += h;
                else begin run = h; fired = 0; prev_s = {s, g}; end

                if (!fired && run >= STABLE_CYC + 1) begin
                    fired = 1;
                    if ($countones(s) == 1) begin
                        d = -1;
                        for (int k = 0; k < 16; k++) if (pat_of(k) == g[6:0]) d = k;
                        pos = (s == 4'b0001) ? 0 : (s == 4'b0010) ? 1 : (s == 4'b0100) ? 2 : 3;
                        if (d < 0) begin
                            exp_err++;
                            have = 0;
                        end else if (pos == have) begin
                            md[pos] = 4'(d); mdp[pos] = g[7]; have++;
                            if (have == 4) begin
                                exp_fr.push_back({mdp, md[3], md[2], md[1], md[0]});
                                have = 0;
                            end
                        end else if (pos == 0) begin
                            md[0] = 4'(d); mdp[0] = g[7]; have = 1;
                        end else begin
                            have = 0;
                        end
                    end
                end
                hold(s, g, h);
            end
            flush();
            chk("rnd_frames", frm_q.size() - nf, exp_fr.size());
            chk("rnd_errs", err_cnt - ne, exp_err);
            chk("rnd_ovf", 32'(ovf), 0);
            for (int i = 0; i < exp_fr.size(); i++)
                if (nf + i < frm_q.size())
                    chk($sformatf("rnd_frame%0d", i), 32'(frm_q[nf + i]), 32'(exp_fr[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/segment_capture.md
SEGMENT_CAPTURE -- requirements
Module: segment_capture

Interface
REQ-001 Parameter STABLE_CYC, default 4, SHALL set the consecutive identical samples needed to accept a digit (legal 2..15).
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 seg  input  8  segment lines {dp,g,f,e,d,c,b,a}, 1 = lit; may be asynchronous.
REQ-005 dig_sel  input  4  one-hot digit enable of the scanned display, bit0 = rightmost digit; may be asynchronous.
REQ-006 value  output  16  captured hex frame, digit3 in [15:12] ... digit0 in [3:0].
REQ-007 dp_out  output  4  captured decimal points, bit i = digit i.
REQ-008 frame_valid  output  1  value/dp_out hold a frame not yet consumed.
REQ-009 frame_ready  input  1  consumer accepts the frame when high with frame_valid.
REQ-010 err  output  1  one-cycle pulse on an undecodable accepted pattern.
REQ-011 ovf  output  1  sticky: a completed frame was dropped.

Function
REQ-012 {dig_sel,seg} SHALL pass through a 2-flop synchronizer before any use.
REQ-013 A stability counter SHALL increment while the synchronized sample equals its previous value, saturate at STABLE_CYC, and clear on any change.
REQ-014 An accept event SHALL fire exactly once per stable run, on the edge the counter reaches STABLE_CYC; a held input never re-fires.
REQ-015 Accepts with dig_sel not one-hot (zero or multi-hot) SHALL be ignored: no state change, no err.
REQ-016 seg[6:0] SHALL decode: 3F=0,06=1,5B=2,4F=3,66=4,6D=5,7D=6,07=7,7F=8,6F=9,77=A,7C=b,39=C,5E=d,79=E,71=F; seg[7] is the digit's dp.
REQ-017 Any other seg[6:0] (including 00) on a valid accept SHALL pulse err for one cycle and return the FSM to IDLE.
REQ-018 FSM states: IDLE, COLLECT; expected index exp (0..3).
REQ-019 IDLE: accept of digit0 -> store digit, exp=1, COLLECT; other digits ignored.
REQ-020 COLLECT: accept of digit exp -> store; if exp=3 frame complete, return IDLE; else exp+1.
REQ-021 COLLECT: accept of digit0 out of order -> restart frame with that digit, exp=1; any other wrong digit -> IDLE, no err.
REQ-022 Frame complete SHALL load value/dp_out and set frame_valid on the next edge if frame_valid is low or frame_ready is high that cycle.
REQ-023 Frame complete while frame_valid=1 and frame_ready=0 SHALL drop the frame, leave value unchanged, and set ovf.
REQ-024 frame_valid SHALL clear on the edge after frame_valid&&frame_ready unless a new frame loads on that edge (REQ-022), then stays high.
REQ-025 value/dp_out SHALL be stable while frame_valid=1.
REQ-026 Latency: last digit input stable at edge E -> frame_valid high after edge E+STABLE_CYC+3.

Reset
REQ-027 rst_n=0 at a clock edge SHALL clear value, dp_out, frame_valid, err, ovf, synchronizer, counter; FSM=IDLE, exp=0.
REQ-028 Reset mid-frame SHALL discard partial digits; the next frame must start at digit0.
REQ-029 ovf SHALL clear only by reset.

Verification
REQ-030 Scan 0001/3F,0010/06,0100/5B,1000/4F each held 8 cycles, frame_ready=1 -> value=16'h3210, dp_out=0, one frame_valid cycle, err=0.
REQ-031 Digit2 pattern 7E -> err single pulse, no frame_valid; next full scan 0..3 of 71 -> value=16'hFFFF.
REQ-032 Each digit held 3 cycles with STABLE_CYC=4 -> no accepts, frame_valid stays 0.
REQ-033 frame_ready=0, two full scans (8421 then 1234 with dp on digit0) -> value=16'h8421 held, ovf=1; frame_ready=1 -> frame_valid clears next edge.
REQ-034 Order 0,1,3 then 0,1,2,3 of 6D -> first frame aborted, value=16'h5555; dig_sel=0011 accepts ignored.
REQ-035 rst_n=0 one edge after digit2 accept, then scan digits 1..3 only -> no frame_valid; outputs 0 after reset.
